// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_e : controller FSM state encoding (also exported on the debug port)
//   - FWD_*      : operand-forwarding select codes
//   - REG_W      : architectural register index width
//   - reg_valid  : tells whether a register index may take part in hazard or
//                  forwarding matching (register 0 is excluded when hardwired)
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_FLUSH      = 2'b11
    } hz_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // A register index can create a dependency unless it is the hardwired zero register.
    function automatic logic reg_valid(input logic [REG_W-1:0] r, input logic zero_hw);
        return !(zero_hw && (r == {REG_W{1'b0}}));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Purely combinational operand-forwarding select for the two EX operands.
// The EX/MEM result is newer than the MEM/WB result, so it wins when both
// match. A load in EX/MEM has no data yet, so it is never a forwarding source.
// Ports:
//   ex_rs1, ex_rs2       : source registers of the instruction in EX
//   mem_rd, mem_rf_le,
//   mem_load             : EX/MEM destination, write enable, load flag
//   wb_rd, wb_rf_le      : MEM/WB destination, write enable
//   fwd_a_sel, fwd_b_sel : FWD_RF / FWD_EXMEM / FWD_MEMWB per operand
// -----------------------------------------------------------------------------
module fwd_unit
    import hazard_pkg::*;
#(
    parameter bit ZERO_REG_HARDWIRED = 1'b1
)
(
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_le,
    input  logic             mem_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_le,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel
);

    logic mem_src_ok_s;
    logic wb_src_ok_s;

    // Select the newest in-flight producer of one source register.
    function automatic logic [1:0] pick_src(input logic [REG_W-1:0] src,
                                            input logic             mem_ok,
                                            input logic [REG_W-1:0] mrd,
                                            input logic             wb_ok,
                                            input logic [REG_W-1:0] wrd);
        logic [1:0] sel;
        if (mem_ok && (mrd == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_ok && (wrd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Qualify each pipeline register as a usable forwarding source.
    always_comb begin
        mem_src_ok_s = mem_rf_le && !mem_load && reg_valid(mem_rd, ZERO_REG_HARDWIRED);
        wb_src_ok_s  = wb_rf_le && reg_valid(wb_rd, ZERO_REG_HARDWIRED);
    end

    // Per-operand forwarding selects.
    always_comb begin
        fwd_a_sel = pick_src(ex_rs1, mem_src_ok_s, mem_rd, wb_src_ok_s, wb_rd);
        fwd_b_sel = pick_src(ex_rs2, mem_src_ok_s, mem_rd, wb_src_ok_s, wb_rd);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall / flush / forwarding controller for the 5-stage pipeline.
// Control outputs are combinational from the FSM state and the current inputs
// so they take effect in the same cycle; state and counters update on clk.
// Priority each cycle: memory busy (full freeze) > taken branch (flush) >
// load-use (one bubble).
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   id_rs1/2, id_use_rs1/2        : ID sources and their use flags
//   ex_rs1/2, ex_rd, ex_rf_le,
//   ex_load                       : ID/EX sources, destination, write enable, load
//   mem_rd, mem_rf_le, mem_load,
//   mem_e                         : EX/MEM destination, write enable, load, access
//   wb_rd, wb_rf_le               : MEM/WB destination, write enable
//   branch_taken, dmem_ready      : EX branch outcome, data memory handshake
//   stat_clr                      : synchronous clear of stall_count
//   pc_le .. mem_wb_le            : pipeline register load enables
//   if_id_flush, id_ex_bubble,
//   mem_wb_bubble                 : NOP insertion controls
//   fwd_a_sel, fwd_b_sel          : operand forwarding selects
//   state                         : FSM state (debug)
//   stall_count                   : saturating count of cycles with pc_le=0
//   mem_timeout_err               : sticky memory wait-state timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT        = 16,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_le,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_le,
    input  logic             mem_load,
    input  logic             mem_e,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_le,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    input  logic             stat_clr,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             id_ex_le,
    output logic             ex_mem_le,
    output logic             mem_wb_le,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       state,
    output logic [15:0]      stall_count,
    output logic             mem_timeout_err
);

    localparam int             CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);

    hz_state_e        state_r;
    hz_state_e        state_nxt_s;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_nxt_s;
    logic             tmo_hit_s;
    logic             mem_timeout_err_r;
    logic [15:0]      stall_count_r;

    logic             mem_busy_s;
    logic             load_use_s;
    logic             lu_enable_s;
    logic             pc_le_s;
    logic             if_id_le_s;
    logic             id_ex_le_s;
    logic             ex_mem_le_s;
    logic             mem_wb_le_s;
    logic             if_id_flush_s;
    logic             id_ex_bubble_s;
    logic             mem_wb_bubble_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    fwd_unit #(
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_fwd (
        .ex_rs1    (ex_rs1),
        .ex_rs2    (ex_rs2),
        .mem_rd    (mem_rd),
        .mem_rf_le (mem_rf_le),
        .mem_load  (mem_load),
        .wb_rd     (wb_rd),
        .wb_rf_le  (wb_rf_le),
        .fwd_a_sel (fwd_a_s),
        .fwd_b_sel (fwd_b_s)
    );

    // Raw hazard terms: outstanding memory access and load-use dependency.
    always_comb begin
        mem_busy_s = mem_e && !dmem_ready;
        load_use_s = 1'b0;
        if (ex_load && ex_rf_le && reg_valid(ex_rd, ZERO_REG_HARDWIRED)) begin
            load_use_s = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Load-use is ignored when ID/EX already holds a bubble (just stalled or flushed).
    always_comb begin
        lu_enable_s = 1'b0;
        case (state_r)
            ST_RUN:        lu_enable_s = 1'b1;
            ST_MEM_WAIT:   lu_enable_s = 1'b1;
            ST_LOAD_STALL: lu_enable_s = 1'b0;
            ST_FLUSH:      lu_enable_s = 1'b0;
            default:       lu_enable_s = 1'b0;
        endcase
    end

    // FSM next state and raw pipeline controls, highest priority hazard first.
    always_comb begin
        state_nxt_s     = ST_RUN;
        pc_le_s         = 1'b1;
        if_id_le_s      = 1'b1;
        id_ex_le_s      = 1'b1;
        ex_mem_le_s     = 1'b1;
        mem_wb_le_s     = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        mem_wb_bubble_s = 1'b0;
        if (mem_busy_s) begin
            // Freeze everything; WB takes a NOP so nothing retires twice.
            pc_le_s         = 1'b0;
            if_id_le_s      = 1'b0;
            id_ex_le_s      = 1'b0;
            ex_mem_le_s     = 1'b0;
            mem_wb_bubble_s = 1'b1;
            state_nxt_s     = ST_MEM_WAIT;
        end else if (branch_taken) begin
            // PC loads the target; squash the two younger instructions.
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            state_nxt_s    = ST_FLUSH;
        end else if (load_use_s && lu_enable_s) begin
            pc_le_s        = 1'b0;
            if_id_le_s     = 1'b0;
            id_ex_bubble_s = 1'b1;
            state_nxt_s    = ST_LOAD_STALL;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // Wait-state timer: counts frozen cycles spent in MEM_WAIT, saturating at the limit.
    always_comb begin
        tmo_cnt_nxt_s = {CNT_W{1'b0}};
        tmo_hit_s     = 1'b0;
        if ((state_r == ST_MEM_WAIT) && mem_busy_s) begin
            if (tmo_cnt_r >= TMO_LIMIT) begin
                tmo_cnt_nxt_s = TMO_LIMIT;
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1'b1);
            end
            tmo_hit_s = (tmo_cnt_nxt_s >= TMO_LIMIT);
        end else begin
            tmo_cnt_nxt_s = {CNT_W{1'b0}};
            tmo_hit_s     = 1'b0;
        end
    end

    // FSM state and wait-state timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_RUN;
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_timeout_err_r <= 1'b0;
        end else if (tmo_hit_s) begin
            mem_timeout_err_r <= 1'b1;
        end else begin
            mem_timeout_err_r <= mem_timeout_err_r;
        end
    end

    // Saturating stall statistics; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 16'h0000;
        end else if (stat_clr) begin
            stall_count_r <= 16'h0000;
        end else if (!pc_le_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'h0001;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // While reset is held the pipeline runs freely with no forwarding.
    always_comb begin
        if (!reset) begin
            pc_le         = 1'b1;
            if_id_le      = 1'b1;
            id_ex_le      = 1'b1;
            ex_mem_le     = 1'b1;
            mem_wb_le     = 1'b1;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            mem_wb_bubble = 1'b0;
            fwd_a_sel     = FWD_RF;
            fwd_b_sel     = FWD_RF;
        end else begin
            pc_le         = pc_le_s;
            if_id_le      = if_id_le_s;
            id_ex_le      = id_ex_le_s;
            ex_mem_le     = ex_mem_le_s;
            mem_wb_le     = mem_wb_le_s;
            if_id_flush   = if_id_flush_s;
            id_ex_bubble  = id_ex_bubble_s;
            mem_wb_bubble = mem_wb_bubble_s;
            fwd_a_sel     = fwd_a_s;
            fwd_b_sel     = fwd_b_s;
        end
    end

    // Status outputs come straight from their registers.
    always_comb begin
        state           = state_r;
        stall_count     = stall_count_r;
        mem_timeout_err = mem_timeout_err_r;
    end

endmodule
